// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin pop scheduler feeding an 8-bit 2:1 mux from two
// upstream FIFOs. Pops are gated by a credit counter that tracks free entries
// in the downstream buffer, and each pop is followed one cycle later by the
// matching mux valid.
`timescale 1ns/1ps

module mux_arbiter #(
   parameter int CREDITS   = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 fifo_empty_0,
   input  logic                 fifo_empty_1,
   input  logic                 fifo_almost_empty_0,
   input  logic                 fifo_almost_empty_1,
   input  logic                 credit_return,
   output logic                 pop_0,
   output logic                 pop_1,
   output logic                 valid_out_0,
   output logic                 valid_out_1,
   output logic [3:0]           credits,
   output logic [1:0]           state,
   output logic [CNT_WIDTH-1:0] grant_count_0,
   output logic [CNT_WIDTH-1:0] grant_count_1,
   output logic                 credit_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

   localparam logic [3:0] CREDITS_MAX = 4'(CREDITS);

   state_t     state_q;
   state_t     state_d;
   logic       last_grant;
   logic       elig_0;
   logic       elig_1;
   logic       grant_ok;
   logic       grant_0;
   logic       grant_1;
   logic       any_grant;
   logic       credits_full;
   logic [3:0] credits_d;

   // A FIFO whose last entry is being popped this cycle must not be popped again.
   assign elig_0       = !fifo_empty_0 && !(pop_0 && fifo_almost_empty_0);
   assign elig_1       = !fifo_empty_1 && !(pop_1 && fifo_almost_empty_1);
   // Only the registered credit count gates a grant; a same-cycle return does not.
   assign grant_ok     = (state_q == RUN) && (credits != 4'd0);
   // last_grant == 1 means channel 0 wins the next contention.
   assign grant_0      = grant_ok && elig_0 && (!elig_1 ||  last_grant);
   assign grant_1      = grant_ok && elig_1 && (!elig_0 || !last_grant);
   assign any_grant    = grant_0 || grant_1;
   assign credits_full = (credits == CREDITS_MAX);

   // Next credit count: a grant consumes one, a return frees one, saturating at the maximum.
   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      credits_d = credits;
      if (any_grant && !credit_return) begin
         credits_d = credits - 4'd1;
      end else if (credit_return && !any_grant && !credits_full) begin
         credits_d = credits + 4'd1;
      end
   end

   // Next-state logic; RUN/STALL decisions look at the credit count after this edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (enable) state_d = RUN;
         end
         RUN: begin
            if (!enable)                  state_d = IDLE;
            else if (credits_d == 4'd0)   state_d = STALL;
         end
         STALL: begin
            if (!enable)                  state_d = IDLE;
            else if (credits_d != 4'd0)   state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset.
   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Pop strobes, delayed valids, credits, grant counters and the sticky credit error.
   always_ff @(posedge clk) begin
      if (reset) begin
         pop_0         <= 1'b0;
         pop_1         <= 1'b0;
         valid_out_0   <= 1'b0;
         valid_out_1   <= 1'b0;
         credits       <= CREDITS_MAX;
         grant_count_0 <= '0;
         grant_count_1 <= '0;
         credit_err    <= 1'b0;
         last_grant    <= 1'b1;
      end else begin
         pop_0       <= grant_0;
         pop_1       <= grant_1;
         // In-flight pops always complete, whatever the state does.
         valid_out_0 <= pop_0;
         valid_out_1 <= pop_1;
         credits     <= credits_d;
         if (grant_0) grant_count_0 <= grant_count_0 + 1'b1;
         if (grant_1) grant_count_1 <= grant_count_1 + 1'b1;
         if (any_grant) last_grant <= grant_1;
         if (credit_return && credits_full) credit_err <= 1'b1;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a cycle-level behavioural model of the scheduler and of
// the two upstream FIFOs.
`timescale 1ns/1ps

module tb_mux_arbiter;

   localparam int CREDITS   = 4;
   localparam int CNT_WIDTH = 8;
   localparam int CNT_MOD   = 1 << CNT_WIDTH;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 enable = 1'b0;
   logic                 credit_return = 1'b0;
   logic                 fifo_empty_0;
   logic                 fifo_empty_1;
   logic                 fifo_almost_empty_0;
   logic                 fifo_almost_empty_1;
   logic                 pop_0;
   logic                 pop_1;
   logic                 valid_out_0;
   logic                 valid_out_1;
   logic [3:0]           credits;
   logic [1:0]           state;
   logic [CNT_WIDTH-1:0] grant_count_0;
   logic [CNT_WIDTH-1:0] grant_count_1;
   logic                 credit_err;

   // Upstream FIFO occupancy, owned by the bench.
   int fcnt [2] = '{0, 0};

   assign fifo_empty_0        = (fcnt[0] == 0);
   assign fifo_empty_1        = (fcnt[1] == 0);
   assign fifo_almost_empty_0 = (fcnt[0] == 1);
   assign fifo_almost_empty_1 = (fcnt[1] == 1);

   mux_arbiter #(.CREDITS(CREDITS), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk                 (clk),
      .reset               (reset),
      .enable              (enable),
      .fifo_empty_0        (fifo_empty_0),
      .fifo_empty_1        (fifo_empty_1),
      .fifo_almost_empty_0 (fifo_almost_empty_0),
      .fifo_almost_empty_1 (fifo_almost_empty_1),
      .credit_return       (credit_return),
      .pop_0               (pop_0),
      .pop_1               (pop_1),
      .valid_out_0         (valid_out_0),
      .valid_out_1         (valid_out_1),
      .credits             (credits),
      .state               (state),
      .grant_count_0       (grant_count_0),
      .grant_count_1       (grant_count_1),
      .credit_err          (credit_err)
   );

   always #5 clk = ~clk;

   // Behavioural model: channel numbers as ints, -1 meaning "none".
   int m_pop      = -1;   // channel whose pop is high this cycle
   int m_valid    = -1;   // channel whose valid is high this cycle
   int m_credits  = CREDITS;
   int m_state    = 0;    // 0 idle, 1 run, 2 stall
   int m_cnt [2]  = '{0, 0};
   int m_last     = 1;
   bit m_err      = 1'b0;
   int pend_drain = -1;   // FIFO that loses an entry at the current edge
   bit auto_ret   = 1'b0; // downstream consumes each valid and returns its credit

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one rising edge using the inputs sampled there.
   task automatic model_edge();
      int g;
      int delta;
      bit e0;
      bit e1;
      pend_drain = m_pop;
      if (reset) begin
         m_pop     = -1;
         m_valid   = -1;
         m_credits = CREDITS;
         m_state   = 0;
         m_cnt[0]  = 0;
         m_cnt[1]  = 0;
         m_err     = 1'b0;
         m_last    = 1;
      end else begin
         e0 = !fifo_empty_0 && !(m_pop == 0 && fifo_almost_empty_0);
         e1 = !fifo_empty_1 && !(m_pop == 1 && fifo_almost_empty_1);
         g  = -1;
         if (m_state == 1 && m_credits > 0) begin
            if (e0 && e1) g = 1 - m_last;
            else if (e0)  g = 0;
            else if (e1)  g = 1;
         end
         delta = (g >= 0 ? -1 : 0) + (credit_return ? 1 : 0);
         if (credit_return && m_credits == CREDITS) begin
            m_err = 1'b1;
            if (delta > 0) delta = 0;
         end
         m_credits += delta;
         case (m_state)
            0:       if (enable) m_state = 1;
            1:       if (!enable) m_state = 0; else if (m_credits == 0) m_state = 2;
            default: if (!enable) m_state = 0; else if (m_credits > 0)  m_state = 1;
         endcase
         m_valid = m_pop;
         m_pop   = g;
         if (g >= 0) begin
            m_cnt[g] = (m_cnt[g] + 1) % CNT_MOD;
            m_last   = g;
         end
      end
   endtask

   // One clock: update model at the edge, then compare outputs 1 ns later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      if (pend_drain >= 0 && fcnt[pend_drain] > 0) fcnt[pend_drain]--;
      check("pop_0",         32'(pop_0),         32'(m_pop == 0));
      check("pop_1",         32'(pop_1),         32'(m_pop == 1));
      check("valid_out_0",   32'(valid_out_0),   32'(m_valid == 0));
      check("valid_out_1",   32'(valid_out_1),   32'(m_valid == 1));
      check("credits",       32'(credits),       32'(m_credits));
      check("state",         32'(state),         32'(m_state));
      check("grant_count_0", 32'(grant_count_0), 32'(m_cnt[0]));
      check("grant_count_1", 32'(grant_count_1), 32'(m_cnt[1]));
      check("credit_err",    32'(credit_err),    32'(m_err));
      if (auto_ret) credit_return = (m_valid >= 0);
   endtask

   task automatic do_reset();
      enable        = 1'b0;
      credit_return = 1'b0;
      reset         = 1'b1;
      step();
      reset         = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pops_seen;
      int seq [$];
      int vseq [$];
      int pidx [$];
      int vidx [$];
      bit found;

      // ---- reset values ----
      do_reset();
      check("rst_credits", 32'(credits), 32'(CREDITS));
      check("rst_state",   32'(state), 32'd0);
      check("rst_pop",     32'({pop_1, pop_0}), 32'd0);

      // ---- alternating pops, credits recycled by the downstream ----
      fcnt[0] = 3; fcnt[1] = 3;
      auto_ret = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (pop_0) begin seq.push_back(0); pidx.push_back(i); end
         if (pop_1) begin seq.push_back(1); pidx.push_back(i); end
         if (valid_out_0) begin vseq.push_back(0); vidx.push_back(i); end
         if (valid_out_1) begin vseq.push_back(1); vidx.push_back(i); end
      end
      check("alt_pop_count", 32'(seq.size()), 32'd6);
      check("alt_val_count", 32'(vseq.size()), 32'd6);
      for (int i = 0; i < seq.size() && i < 6; i++) begin
         check("alt_pop_chan", 32'(seq[i]), 32'(i % 2));
         check("alt_pop_back2back", 32'(pidx[i]), 32'(pidx[0] + i));
      end
      for (int i = 0; i < vseq.size() && i < seq.size(); i++) begin
         check("alt_val_chan", 32'(vseq[i]), 32'(seq[i]));
         check("alt_val_delay", 32'(vidx[i]), 32'(pidx[i] + 1));
      end
      check("alt_gc0", 32'(grant_count_0), 32'd3);
      check("alt_gc1", 32'(grant_count_1), 32'd3);
      check("alt_err", 32'(credit_err), 32'd0);
      auto_ret = 1'b0;

      // ---- single-entry FIFO 1: almost-empty blocks the second pop ----
      do_reset();
      fcnt[0] = 0; fcnt[1] = 1;
      enable = 1'b1;
      pops_seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (pop_1) pops_seen++;
         check("single_no_pop0", 32'(pop_0), 32'd0);
      end
      check("single_pop1_count", 32'(pops_seen), 32'd1);
      check("single_credits", 32'(credits), 32'd3);

      // ---- credit exhaustion and one-credit release ----
      do_reset();
      fcnt[0] = 20; fcnt[1] = 20;
      enable = 1'b1;
      pops_seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (pop_0 || pop_1) pops_seen++;
      end
      check("exh_pops", 32'(pops_seen), 32'd4);
      check("exh_state", 32'(state), 32'd2);
      check("exh_credits", 32'(credits), 32'd0);
      credit_return = 1'b1;
      step();
      credit_return = 1'b0;
      pops_seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (pop_0 || pop_1) pops_seen++;
      end
      check("rel_pops", 32'(pops_seen), 32'd1);
      check("rel_state", 32'(state), 32'd2);
      check("rel_credits", 32'(credits), 32'd0);

      // ---- return coinciding with a grant ----
      do_reset();
      fcnt[0] = 20; fcnt[1] = 20;
      enable = 1'b1;
      step();              // IDLE -> RUN, no pop
      step();              // first grant, credits 4 -> 3
      check("cg_before", 32'(credits), 32'd3);
      credit_return = 1'b1;
      step();              // grant and return together
      credit_return = 1'b0;
      check("cg_pop", 32'(pop_0 || pop_1), 32'd1);
      check("cg_credits", 32'(credits), 32'd3);

      // ---- return while full: saturate and flag ----
      do_reset();
      credit_return = 1'b1;
      step();
      credit_return = 1'b0;
      check("ovf_credits", 32'(credits), 32'd4);
      check("ovf_err", 32'(credit_err), 32'd1);
      for (int i = 0; i < 3; i++) step();
      check("ovf_err_sticky", 32'(credit_err), 32'd1);
      do_reset();
      check("ovf_err_cleared", 32'(credit_err), 32'd0);

      // ---- reset right after a pop drops the pending valid ----
      fcnt[0] = 20; fcnt[1] = 20;
      enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (pop_0) found = 1'b1;
      end
      check("mid_pop0_seen", 32'(found), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_valid0", 32'(valid_out_0), 32'd0);
      check("mid_credits", 32'(credits), 32'd4);
      check("mid_state", 32'(state), 32'd0);
      step();              // IDLE -> RUN
      step();              // first contention after reset
      check("mid_first_pop0", 32'(pop_0), 32'd1);
      check("mid_first_pop1", 32'(pop_1), 32'd0);

      // ---- 300 pops on channel 0: counter wraps ----
      do_reset();
      fcnt[0] = 300; fcnt[1] = 0;
      auto_ret = 1'b1;
      enable = 1'b1;
      pops_seen = 0;
      for (int i = 0; i < 600 && !(fcnt[0] == 0 && !pop_0 && i > 2); i++) begin
         step();
         if (pop_0) pops_seen++;
      end
      check("wrap_pops", 32'(pops_seen), 32'd300);
      check("wrap_gc0", 32'(grant_count_0), 32'd44);
      auto_ret = 1'b0;

      // ---- randomized traffic against the model ----
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         for (int c = 0; c < 2; c++)
            if ($urandom_range(0, 3) == 0) fcnt[c] += $urandom_range(0, 3);
         enable        = ($urandom_range(0, 15) != 0);
         credit_return = (m_valid >= 0 && $urandom_range(0, 3) != 0) || ($urandom_range(0, 39) == 0);
         reset         = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
